// File: rtl/sram_to_sram_multi_core.sv
// CH-lane SRAM-to-SRAM stream with a registered neighbour ALU; write k lands RD_LATENCY+1 cycles after read k.
// cke=0 freezes everything; define SRAM_TO_SRAM_MULTI_CORE_SATURATE_EN for saturating add/sub.
module sram_to_sram_multi_core #(
  parameter int CH         = 4,
  parameter int ADDR_BITS  = 10,
  parameter int DATA_BITS  = 64,
  parameter int RD_LATENCY = 1
) (
  input  logic                               clk,
  input  logic                               reset,
  input  logic                               cke,
  input  logic                               start,
  input  logic [ADDR_BITS-1:0]               src_base,
  input  logic [ADDR_BITS-1:0]               dst_base,
  input  logic [ADDR_BITS:0]                 len,
  input  logic [1:0]                         mode,
  output logic                               busy,
  output logic                               done,
  output logic [CH-1:0]                      mem_ren,
  output logic [CH-1:0][ADDR_BITS-1:0]       mem_raddr,
  input  logic [CH-1:0][DATA_BITS-1:0]       mem_rdata,
  output logic [CH-1:0]                      mem_wen,
  output logic [CH-1:0][ADDR_BITS-1:0]       mem_waddr,
  output logic [CH-1:0][DATA_BITS-1:0]       mem_wdata
);
  typedef logic [ADDR_BITS-1:0] addr_t;
  typedef logic [DATA_BITS-1:0] data_t;
  typedef enum logic [1:0] {IDLE = 2'd0, READ = 2'd1, DRAIN = 2'd2} state_t;

  state_t                state_q, state_d;
  addr_t                 src_q, src_d, dst_q, dst_d;
  addr_t                 wr_cnt_q, wr_cnt_d, waddr_q, waddr_d;
  logic [ADDR_BITS:0]    len_q, len_d, rd_cnt_q, rd_cnt_d;
  logic [1:0]            mode_q, mode_d;
  logic [RD_LATENCY-1:0] vld_q, vld_d;
  logic                  wen_q, wen_d, commit_q, commit_d;
  data_t [CH-1:0]        wdata_q, wdata_d, alu_res;
  logic                  rd_active, pipe_empty, finish;

  function automatic data_t alu(input logic [1:0] op, input data_t a, input data_t b);
    data_t r;
`ifdef SRAM_TO_SRAM_MULTI_CORE_SATURATE_EN
    logic [DATA_BITS:0] sum;
    sum = {1'b0, a} + {1'b0, b};
`endif
    case (op)
      2'b00: r = a;
`ifdef SRAM_TO_SRAM_MULTI_CORE_SATURATE_EN
      2'b01: r = sum[DATA_BITS] ? '1 : sum[DATA_BITS-1:0];
      2'b10: r = (a < b) ? '0 : a - b;
`else
      2'b01: r = a + b;
      2'b10: r = a - b;
`endif
      default: r = a ^ b;
    endcase
    return r;
  endfunction

  // Lane i pairs with lane i+1; the last lane wraps to lane 0 (itself when CH=1).
  for (genvar i = 0; i < CH; i++) begin : g_lane
    localparam int NB = (i + 1) % CH;
    assign alu_res[i]   = alu(mode_q, mem_rdata[i], mem_rdata[NB]);
    assign mem_raddr[i] = src_q + rd_cnt_q[ADDR_BITS-1:0];
    assign mem_waddr[i] = waddr_q;
  end

  assign rd_active  = (state_q == READ);
  // commit_q holds off done for one cycle so the final write has settled in the SRAM.
  assign pipe_empty = (vld_q == '0) && !wen_q && !commit_q;
  assign finish     = (state_q == DRAIN) && pipe_empty;
  assign busy       = (state_q != IDLE) && !finish;
  assign done       = finish && cke;
  assign mem_ren    = {CH{rd_active && cke}};
  assign mem_wen    = {CH{wen_q && cke}};
  assign mem_wdata  = wdata_q;

  always_comb begin
    state_d  = state_q;
    src_d    = src_q;
    dst_d    = dst_q;
    len_d    = len_q;
    mode_d   = mode_q;
    rd_cnt_d = rd_cnt_q;
    wr_cnt_d = wr_cnt_q;
    waddr_d  = waddr_q;
    vld_d    = vld_q;
    wen_d    = wen_q;
    commit_d = commit_q;
    wdata_d  = wdata_q;
    if (cke) begin
      vld_d[0] = rd_active;
      for (int i = 1; i < RD_LATENCY; i++) vld_d[i] = vld_q[i-1];
      wen_d    = vld_q[RD_LATENCY-1];
      commit_d = wen_q;
      if (vld_q[RD_LATENCY-1]) begin
        wdata_d  = alu_res;
        waddr_d  = dst_q + wr_cnt_q;
        wr_cnt_d = wr_cnt_q + 1'b1;
      end
      case (state_q)
        IDLE: begin
          if (start) begin
            src_d    = src_base;
            dst_d    = dst_base;
            len_d    = len;
            mode_d   = mode;
            rd_cnt_d = '0;
            wr_cnt_d = '0;
            state_d  = (len == '0) ? DRAIN : READ;
          end
        end
        READ: begin
          rd_cnt_d = rd_cnt_q + 1'b1;
          if (rd_cnt_q == len_q - 1'b1) state_d = DRAIN;
        end
        DRAIN: begin
          if (pipe_empty) state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      src_q    <= '0;
      dst_q    <= '0;
      len_q    <= '0;
      mode_q   <= '0;
      rd_cnt_q <= '0;
      wr_cnt_q <= '0;
      waddr_q  <= '0;
      vld_q    <= '0;
      wen_q    <= 1'b0;
      commit_q <= 1'b0;
      wdata_q  <= '0;
    end else begin
      state_q  <= state_d;
      src_q    <= src_d;
      dst_q    <= dst_d;
      len_q    <= len_d;
      mode_q   <= mode_d;
      rd_cnt_q <= rd_cnt_d;
      wr_cnt_q <= wr_cnt_d;
      waddr_q  <= waddr_d;
      vld_q    <= vld_d;
      wen_q    <= wen_d;
      commit_q <= commit_d;
      wdata_q  <= wdata_d;
    end
  end
endmodule

// File: tb/tb_sram_to_sram_multi_core.sv
// Directed bench for sram_to_sram_multi_core: vector table plus cke-toggle and mid-transfer reset sequences.
`timescale 1ns/1ps
module tb_sram_to_sram_multi_core;
  localparam int CH = 4, AB = 10, DB = 64, RDL = 1;
  localparam logic [DB-1:0] ONES = '1;
  localparam logic [DB-1:0] H63  = 64'h8000_0000_0000_0000;

  logic clk = 1'b0, reset = 1'b1, cke = 1'b1, start = 1'b0;
  logic [AB-1:0] src_base = '0, dst_base = '0;
  logic [AB:0]   len = '0;
  logic [1:0]    mode = '0;
  logic busy, done;
  logic [CH-1:0] mem_ren, mem_wen;
  logic [CH-1:0][AB-1:0] mem_raddr, mem_waddr;
  logic [CH-1:0][DB-1:0] mem_rdata, mem_wdata;

  always #5 clk = ~clk;

  sram_to_sram_multi_core #(.CH(CH), .ADDR_BITS(AB), .DATA_BITS(DB), .RD_LATENCY(RDL)) dut (
    .clk(clk), .reset(reset), .cke(cke), .start(start),
    .src_base(src_base), .dst_base(dst_base), .len(len), .mode(mode),
    .busy(busy), .done(done),
    .mem_ren(mem_ren), .mem_raddr(mem_raddr), .mem_rdata(mem_rdata),
    .mem_wen(mem_wen), .mem_waddr(mem_waddr), .mem_wdata(mem_wdata)
  );

  // Source SRAM model (latency 1, shares cke) and write/read monitor.
  logic [DB-1:0] src_mem [CH][1024];
  typedef struct packed {
    logic [CH-1:0][AB-1:0] addr;
    logic [CH-1:0][DB-1:0] dat;
  } wr_t;
  wr_t wlog[$];
  int ren_cnt = 0, done_cnt = 0, gate_bad = 0, split_bad = 0;

  always @(posedge clk) begin
    if (cke) begin
      for (int i = 0; i < CH; i++)
        if (mem_ren[i]) mem_rdata[i] <= src_mem[i][mem_raddr[i]];
      if (|mem_ren) ren_cnt++;
      if (|mem_wen) wlog.push_back('{addr: mem_waddr, dat: mem_wdata});
      if (done) done_cnt++;
      if ((mem_ren != '0 && mem_ren != '1) || (mem_wen != '0 && mem_wen != '1)) split_bad++;
    end else if (|mem_ren || |mem_wen || done) begin
      gate_bad++;
    end
  end

  int n_chk = 0, n_fail = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  typedef struct {
    logic [AB-1:0]         src, dst;
    logic [AB:0]           len;
    logic [1:0]            mode;
    bit                    konst;   // 1: each lane holds val[i] everywhere; 0: word = addr + 16*lane
    logic [CH-1:0][DB-1:0] val;
    logic [CH-1:0][DB-1:0] exp;
    int                    exp_done;
  } vec_t;

  function automatic logic [CH-1:0][DB-1:0] c4(input logic [DB-1:0] a0, a1, a2, a3);
    return {a3, a2, a1, a0};
  endfunction

  function automatic vec_t mkv(input logic [AB-1:0] s, d, input logic [AB:0] l, input logic [1:0] m,
                               input bit k, input logic [CH-1:0][DB-1:0] val, exp, input int ed);
    vec_t v;
    v.src = s; v.dst = d; v.len = l; v.mode = m; v.konst = k; v.val = val; v.exp = exp; v.exp_done = ed;
    return v;
  endfunction

  task automatic fill(input vec_t v);
    for (int i = 0; i < CH; i++)
      for (int a = 0; a < 1024; a++)
        src_mem[i][a] = v.konst ? v.val[i] : DB'(a + 16 * i);
  endtask

  function automatic logic [DB-1:0] exp_dat(input vec_t v, input int i, input int k);
    if (v.konst) return v.exp[i];
    return DB'(((int'(v.src) + k) % 1024) + 16 * i);
  endfunction

  task automatic check_writes(input vec_t v, input int wb, input string tag);
    logic [AB-1:0] ea;
    for (int k = 0; k < int'(v.len) && wb + k < wlog.size(); k++) begin
      ea = v.dst + AB'(k);
      for (int i = 0; i < CH; i++) begin
        chk($sformatf("%s_waddr_k%0d_ch%0d", tag, k, i), 64'(wlog[wb+k].addr[i]), 64'(ea));
        chk($sformatf("%s_wdata_k%0d_ch%0d", tag, k, i), wlog[wb+k].dat[i], exp_dat(v, i, k));
      end
    end
  endtask

  task automatic run_vec(input vec_t v, input string tag);
    int cyc, rb, wb;
    fill(v);
    rb = ren_cnt; wb = wlog.size();
    src_base = v.src; dst_base = v.dst; len = v.len; mode = v.mode; start = 1'b1;
    tick();
    start = 1'b0; cyc = 1;
    chk({tag, "_busy_c1"}, 64'(busy), 64'(v.len != 0));
    while (!done && cyc < 1100) begin
      tick();
      cyc++;
    end
    chk({tag, "_done_cycle"}, 64'(cyc), 64'(v.exp_done));
    chk({tag, "_busy_at_done"}, 64'(busy), 64'd0);
    tick();
    chk({tag, "_done_pulse"}, 64'(done), 64'd0);
    chk({tag, "_n_writes"}, 64'(wlog.size() - wb), 64'(v.len));
    chk({tag, "_n_reads"}, 64'(ren_cnt - rb), 64'(v.len));
    check_writes(v, wb, tag);
  endtask

  vec_t vt[8];
  vec_t vc, vr;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int cyc, guard, rb, wb, db, gb, sb;
    bit c_prev;

    vt[0] = mkv(10'h000, 10'h100, 11'd8, 2'b00, 1'b0, '0, '0, 12);
    vt[1] = mkv(10'h010, 10'h040, 11'd4, 2'b01, 1'b1, c4(5, 7, 1, 9), c4(12, 8, 10, 14), 8);
`ifdef SRAM_TO_SRAM_MULTI_CORE_SATURATE_EN
    vt[2] = mkv(10'h020, 10'h050, 11'd2, 2'b10, 1'b1, c4(1, 2, 0, 0), c4(0, 2, 0, 0), 6);
    vt[3] = mkv(10'h030, 10'h060, 11'd1, 2'b01, 1'b1, c4(H63, H63, 0, 0), c4(ONES, H63, 0, H63), 5);
`else
    vt[2] = mkv(10'h020, 10'h050, 11'd2, 2'b10, 1'b1, c4(1, 2, 0, 0), c4(ONES, 2, 0, ONES), 6);
    vt[3] = mkv(10'h030, 10'h060, 11'd1, 2'b01, 1'b1, c4(H63, H63, 0, 0), c4(0, H63, 0, H63), 5);
`endif
    vt[4] = mkv(10'h040, 10'h070, 11'd3, 2'b11, 1'b1, c4(64'hF0, 64'h3C, 64'hFF, 0),
                c4(64'hCC, 64'hC3, 64'hFF, 64'hF0), 7);
    vt[5] = mkv(10'h3FE, 10'h3FF, 11'd3, 2'b00, 1'b0, '0, '0, 7);
    vt[6] = mkv(10'h100, 10'h200, 11'd0, 2'b00, 1'b0, '0, '0, 1);
    vt[7] = mkv(10'h005, 10'h007, 11'd1024, 2'b00, 1'b0, '0, '0, 1028);

    // Reset state
    repeat (3) tick();
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_ren", 64'(mem_ren), 64'd0);
    chk("rst_wen", 64'(mem_wen), 64'd0);
    chk("rst_raddr_zero", 64'(mem_raddr == '0), 64'd1);
    chk("rst_waddr_zero", 64'(mem_waddr == '0), 64'd1);
    chk("rst_wdata_zero", 64'(mem_wdata == '0), 64'd1);
    reset = 1'b0;
    tick();

    for (int n = 0; n < 8; n++) run_vec(vt[n], $sformatf("vec%0d", n));

    // Random cke with ignored start pulses while busy
    vc = mkv(10'h020, 10'h200, 11'd16, 2'b00, 1'b0, '0, '0, 20);
    fill(vc);
    rb = ren_cnt; wb = wlog.size(); gb = gate_bad; sb = split_bad;
    src_base = vc.src; dst_base = vc.dst; len = vc.len; mode = vc.mode; start = 1'b1; cke = 1'b1;
    tick();
    cyc = 1; guard = 0;
    cke = 1'($urandom_range(0, 1)); start = 1'b1; src_base = 10'h300; dst_base = 10'h000;
    len = 11'd5; mode = 2'b11;
    #1;
    while (!done && guard < 400) begin
      c_prev = cke;
      tick();
      if (c_prev) cyc++;
      cke = 1'($urandom_range(0, 1));
      start = 1'($urandom_range(0, 1));
      #1;
      guard++;
    end
    start = 1'b0; cke = 1'b1;
    chk("cke_done_cycle", 64'(cyc), 64'(vc.exp_done));
    tick();
    chk("cke_n_writes", 64'(wlog.size() - wb), 64'd16);
    chk("cke_n_reads", 64'(ren_cnt - rb), 64'd16);
    chk("cke_gated_outputs", 64'(gate_bad - gb), 64'd0);
    chk("cke_lanes_together", 64'(split_bad - sb), 64'd0);
    check_writes(vc, wb, "cke");

    // Reset in the 5th cycle of a len-32 transfer
    vr = mkv(10'h000, 10'h080, 11'd32, 2'b00, 1'b0, '0, '0, 36);
    fill(vr);
    wb = wlog.size(); db = done_cnt;
    src_base = vr.src; dst_base = vr.dst; len = vr.len; mode = vr.mode; start = 1'b1;
    tick();
    start = 1'b0;
    repeat (4) tick();
    reset = 1'b1;
    tick();
    chk("midrst_busy", 64'(busy), 64'd0);
    chk("midrst_done", 64'(done), 64'd0);
    chk("midrst_ren", 64'(mem_ren), 64'd0);
    chk("midrst_wen", 64'(mem_wen), 64'd0);
    chk("midrst_raddr_zero", 64'(mem_raddr == '0), 64'd1);
    chk("midrst_waddr_zero", 64'(mem_waddr == '0), 64'd1);
    chk("midrst_wdata_zero", 64'(mem_wdata == '0), 64'd1);
    reset = 1'b0;
    repeat (10) tick();
    chk("midrst_n_writes", 64'(wlog.size() - wb), 64'd3);
    chk("midrst_no_done", 64'(done_cnt - db), 64'd0);
    run_vec(vt[0], "after_rst");

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
